// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M-style multiply/divide unit.
//
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// cycle on operand magnitudes, followed by a single sign-fix cycle. Divide
// by zero and signed overflow bypass the datapath and complete directly.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   flush         synchronous abort of any in-flight operation
//   in_valid      request valid
//   in_ready      unit can accept a request (high only in IDLE)
//   md_op_select  funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   opd1          rs1 (multiplicand / dividend)
//   opd2          rs2 (multiplier / divisor)
//   out_valid     result available
//   out_ready     consumer takes the result
//   md_result     result word, defined only while out_valid is high
//   busy          high in every state except IDLE
module muldiv_unit #(
    parameter int unsigned OPERAND_LENGTH = 32,
    parameter int unsigned CNT_WIDTH      = $clog2(OPERAND_LENGTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                md_op_select,
    input  logic [OPERAND_LENGTH-1:0] opd1,
    input  logic [OPERAND_LENGTH-1:0] opd2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OPERAND_LENGTH-1:0] md_result,
    output logic                      busy
);

    localparam int unsigned W = OPERAND_LENGTH;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(OPERAND_LENGTH - 1);
    localparam logic [W-1:0]         MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    state_e               state_q;
    op_e                  op_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [W-1:0]         b_q;        // multiplicand (mul) or divisor (div) magnitude
    logic [2*W-1:0]       acc_q;      // {hi, lo}: product, or {remainder, quotient}
    logic                 neg_res_q;  // negate product / quotient
    logic                 neg_rem_q;  // negate remainder (dividend was negative)
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 busy_q;
    logic [W-1:0]         md_result_q;

    // ---------------- request decode ----------------
    op_e          op_in;
    logic         sgn1, sgn2;
    logic [W-1:0] mag1, mag2;
    logic         div_zero, div_ovf;
    logic [W-1:0] special_d;

    always_comb begin
        op_in     = op_e'(md_op_select);
        sgn1      = opd1[W-1] & (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        sgn2      = opd2[W-1] & (op_in inside {OP_MULH, OP_DIV, OP_REM});
        mag1      = sgn1 ? -opd1 : opd1;
        mag2      = sgn2 ? -opd2 : opd2;
        div_zero  = md_op_select[2] && (opd2 == '0);
        div_ovf   = (op_in inside {OP_DIV, OP_REM}) && (opd1 == MOST_NEG) && (opd2 == '1);
        special_d = '0;
        if (div_zero)
            special_d = (op_in inside {OP_REM, OP_REMU}) ? opd1 : '1;
        else if (div_ovf)
            special_d = (op_in == OP_REM) ? '0 : opd1;
    end

    // ---------------- iteration step ----------------
    logic [W:0]     mul_sum;
    logic [W:0]     div_shift;
    logic [W-1:0]   div_diff;
    logic           div_ge;
    logic [2*W-1:0] acc_d;

    always_comb begin
        // multiply: conditionally add multiplicand into the high half, shift right
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
        // divide: shift next dividend bit into the partial remainder, trial subtract
        div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
        div_ge    = div_shift >= {1'b0, b_q};
        div_diff  = div_shift[W-1:0] - b_q;
        if (op_q[2])
            acc_d = {(div_ge ? div_diff : div_shift[W-1:0]), acc_q[W-2:0], div_ge};
        else
            acc_d = {mul_sum, acc_q[W-1:1]};
    end

    // ---------------- sign fix and word select ----------------
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   quo_s, rem_s, result_d;

    always_comb begin
        prod_s = neg_res_q ? -acc_q : acc_q;
        quo_s  = neg_res_q ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem_s  = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        case (op_q)
            OP_MUL:                       result_d = prod_s[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_s[2*W-1:W];
            OP_DIV, OP_DIVU:              result_d = quo_s;
            default:                      result_d = rem_s;
        endcase
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_MUL;
            cnt_q       <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            md_result_q <= '0;
        end else if (flush) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        op_q       <= op_in;
                        neg_res_q  <= sgn1 ^ sgn2;
                        neg_rem_q  <= sgn1;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (md_op_select[2]) begin
                            acc_q <= {{W{1'b0}}, mag1};
                            b_q   <= mag2;
                        end else begin
                            acc_q <= {{W{1'b0}}, mag2};
                            b_q   <= mag1;
                        end
                        if (div_zero || div_ovf) begin
                            md_result_q <= special_d;
                            state_q     <= DONE;
                        end else begin
                            state_q     <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= FIX;
                    end else begin
                        cnt_q   <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                FIX: begin
                    md_result_q <= result_d;
                    state_q     <= DONE;
                end
                DONE: begin
                    // out_valid rises one cycle after DONE is entered, so a
                    // result is only offered once md_result has settled for a
                    // full cycle; the handshake is keyed on the registered flag.
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign md_result = md_result_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit at OPERAND_LENGTH=32.
// Expected results come from a 64-bit arithmetic reference model of the
// RV32M operation set; expected latencies come from the special-case rules.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  md_op_select;
    logic [31:0] opd1;
    logic [31:0] opd2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] md_result;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.OPERAND_LENGTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .md_op_select (md_op_select),
        .opd1         (opd1),
        .opd2         (opd2),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .md_result    (md_result),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (op)
            3'd0: begin p = ua * ub;           return p[31:0];  end
            3'd1: begin p = sa * sb;           return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub;           return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a;             p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a;          p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic int model_latency(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        bit is_div, is_signed_div;
        is_div        = (op >= 3'd4);
        is_signed_div = (op == 3'd4) || (op == 3'd6);
        if (is_div && (b == 0)) return 1;
        if (is_signed_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        md_op_select = op;
        opd1         = a;
        opd2         = b;
        in_valid     = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b);
        int lat;
        bit busy_ok;
        lat     = 0;
        busy_ok = 1'b1;
        while (lat < 200) begin
            if (out_valid) break;
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_result"}, 64'(md_result), 64'(model(op, a, b)));
        check({tag, "_latency"}, 64'(lat), 64'(model_latency(op, a, b)));
        check({tag, "_busy"}, 64'(busy_ok), 64'd1);
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        start_op(op, a, b);
        wait_result(tag, op, a, b);
        @(posedge clk);
        #1;
        check({tag, "_ack"}, 64'(out_valid), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ra, rb, exp_bp;
        logic [2:0]  rop;
        bit          ov_seen;

        rst_n        = 1'b0;
        flush        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        md_op_select = '0;
        opd1         = '0;
        opd2         = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_md_result", 64'(md_result), 64'd0);
        rst_n = 1'b1;

        // directed operations
        do_op("mul_7_m3",   3'd0, 32'd7,          32'hFFFF_FFFD);
        do_op("mulh_min",   3'd1, 32'h8000_0000,  32'h8000_0000);
        do_op("mulhu_max",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
        do_op("mulhsu_max", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
        do_op("mul_zero",   3'd0, 32'h1234_5678,  32'd0);
        do_op("div_m7_2",   3'd4, 32'hFFFF_FFF9,  32'd2);
        do_op("rem_m7_2",   3'd6, 32'hFFFF_FFF9,  32'd2);
        do_op("divu_100_7", 3'd5, 32'd100,        32'd7);
        do_op("remu_100_7", 3'd7, 32'd100,        32'd7);
        do_op("div_by0",    3'd4, 32'd5,          32'd0);
        do_op("remu_by0",   3'd7, 32'd5,          32'd0);
        do_op("div_ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF);
        do_op("rem_ovf",    3'd6, 32'h8000_0000,  32'hFFFF_FFFF);
        do_op("divu_min_m1",3'd5, 32'h8000_0000,  32'hFFFF_FFFF);

        // randomized operations with biased corner operands
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'd0;
                2:       ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            do_op("rand", rop, ra, rb);
        end

        // backpressure: result held in DONE while in_valid toggles
        out_ready = 1'b0;
        start_op(3'd5, 32'd1000, 32'd7);
        wait_result("bp_first", 3'd5, 32'd1000, 32'd7);
        exp_bp = model(3'd5, 32'd1000, 32'd7);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid     = i[0];
            opd1         = $urandom;
            opd2         = $urandom;
            md_op_select = 3'($urandom_range(0, 7));
            @(posedge clk);
            #1;
            check("bp_result",   64'(md_result), 64'(exp_bp));
            check("bp_valid",    64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready),  64'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_ready", 64'(in_ready),  64'd1);
        @(posedge clk);
        #1;
        check("bp_no_queue", 64'(busy), 64'd0);

        // flush beats acceptance in IDLE
        @(negedge clk);
        md_op_select = 3'd0;
        opd1         = 32'd3;
        opd2         = 32'd4;
        in_valid     = 1'b1;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_idle_busy", 64'(busy), 64'd0);

        // flush at CALC counter 10
        start_op(3'd0, 32'h0001_2345, 32'h0000_0777);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy",     64'(busy),      64'd0);
        check("flush_in_ready", 64'(in_ready),  64'd1);
        ov_seen = 1'b0;
        repeat (40) begin
            if (out_valid) ov_seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check("flush_no_valid", 64'(ov_seen), 64'd0);

        // reset at CALC counter 20
        start_op(3'd4, 32'd12345, 32'hFFFF_FFF9);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy",      64'(busy),      64'd0);
        check("midrst_in_ready",  64'(in_ready),  64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_md_result", 64'(md_result), 64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        ov_seen = 1'b0;
        repeat (40) begin
            if (out_valid) ov_seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check("midrst_no_valid", 64'(ov_seen), 64'd0);

        do_op("divu_9_3", 3'd5, 32'd9, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
